// File: rtl/i2c_target_if.sv
// rtl/i2c_target_if.sv - I2C bus pins seen by the target (SCL/SDA in, open-drain SDA out)
interface i2c_target_if;
    logic scl_i;
    logic sda_i;
    logic sda_o;
    logic sda_t_o;

    modport slave (
        input  scl_i,
        input  sda_i,
        output sda_o,
        output sda_t_o
    );

    modport master (
        output scl_i,
        output sda_i,
        input  sda_o,
        input  sda_t_o
    );
endinterface

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - LM75-style I2C target with pointer byte and 4-byte register file
module i2c_target #(
    parameter logic [6:0] ADDR        = 7'b1001000,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    i2c_target_if.slave bus,
    input  logic [7:0]  temp_i,
    output logic [23:0] cfg_o,
    output logic        wr_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WDATA, S_WACK, S_RDATA, S_RACK
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;
    logic [3:0]             bit_cnt;
    logic [7:0]             shift;
    logic [7:0]             tx;
    logic                   rw;
    logic                   first_byte;
    logic                   mack;
    logic [1:0]             ptr;
    logic [23:0]            cfg;
    logic                   wr;
    logic                   sda_t;
    logic [7:0]             rd_byte;

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & sda_prev & ~sda_s;
    assign stop_det  = scl_s & ~sda_prev & sda_s;

    assign bus.sda_t_o = sda_t;
    assign bus.sda_o   = ~sda_t;
    assign cfg_o       = cfg;
    assign wr_o        = wr;
    assign busy_o      = (state != S_IDLE);

    // Byte returned to the master for the current pointer; register 0 mirrors the sensor.
    always_comb begin
        rd_byte = temp_i;
        case (ptr)
            2'd1:    rd_byte = cfg[7:0];
            2'd2:    rd_byte = cfg[15:8];
            2'd3:    rd_byte = cfg[23:16];
            default: rd_byte = temp_i;
        endcase
    end

    // Synchronise the asynchronous bus lines and keep one-cycle-old copies for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    // Protocol FSM: STOP beats START beats normal bit handling; SDA only moves after an SCL fall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            bit_cnt    <= 4'd0;
            shift      <= 8'd0;
            tx         <= 8'd0;
            rw         <= 1'b0;
            first_byte <= 1'b0;
            mack       <= 1'b1;
            ptr        <= 2'd0;
            cfg        <= 24'd0;
            wr         <= 1'b0;
            sda_t      <= 1'b0;
        end else begin
            wr <= 1'b0;
            if (stop_det) begin
                state <= S_IDLE;
                sda_t <= 1'b0;
            end else if (start_det) begin
                state   <= S_ADDR;
                bit_cnt <= 4'd0;
                sda_t   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: sda_t <= 1'b0;
                    S_ADDR, S_WDATA: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (state == S_ADDR) begin
                                if (shift[7:1] == ADDR) begin
                                    state <= S_ADDR_ACK;
                                    rw    <= shift[0];
                                    sda_t <= 1'b1;
                                end else begin
                                    state <= S_IDLE;
                                end
                            end else begin
                                state <= S_WACK;
                                sda_t <= 1'b1;
                                if (first_byte) begin
                                    ptr        <= shift[1:0];
                                    first_byte <= 1'b0;
                                end else begin
                                    if (ptr != 2'd0) begin
                                        wr <= 1'b1;
                                        case (ptr)
                                            2'd1:    cfg[7:0]   <= shift;
                                            2'd2:    cfg[15:8]  <= shift;
                                            default: cfg[23:16] <= shift;
                                        endcase
                                    end
                                    ptr <= ptr + 2'd1;
                                end
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            if (rw) begin
                                state <= S_RDATA;
                                tx    <= rd_byte;
                                sda_t <= ~rd_byte[7];
                            end else begin
                                state      <= S_WDATA;
                                first_byte <= 1'b1;
                                sda_t      <= 1'b0;
                            end
                        end
                    end
                    S_WACK: begin
                        if (scl_fall) begin
                            state   <= S_WDATA;
                            bit_cnt <= 4'd0;
                            sda_t   <= 1'b0;
                        end
                    end
                    S_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                state <= S_RACK;
                                sda_t <= 1'b0;
                                ptr   <= ptr + 2'd1;
                            end else begin
                                tx    <= {tx[6:0], 1'b0};
                                sda_t <= ~tx[6];
                            end
                        end
                    end
                    S_RACK: begin
                        if (scl_rise) begin
                            mack <= sda_s;
                        end else if (scl_fall) begin
                            if (!mack) begin
                                state   <= S_RDATA;
                                bit_cnt <= 4'd0;
                                tx      <= rd_byte;
                                sda_t   <= ~rd_byte[7];
                            end else begin
                                state <= S_IDLE;
                                sda_t <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        sda_t <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - randomized I2C master driving i2c_target against a register-file model
module tb_i2c_target;

    localparam int T = 200;
    localparam int Q = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic [7:0]  temp = 8'h00;
    logic [23:0] cfg;
    logic        wr;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int proto_bad = 0;
    bit sda_t_seen = 1'b0;
    logic scl_prev_tb = 1'b1;
    logic sdat_prev = 1'b0;

    logic [7:0] m_reg [4];
    int         m_ptr = 0;
    int         m_wr = 0;
    logic [7:0] wbuf [8];

    i2c_target_if bus ();
    assign bus.scl_i = scl_m;
    assign bus.sda_i = sda_m & ~bus.sda_t_o;

    i2c_target #(.ADDR(7'h48), .SYNC_STAGES(2)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus.slave),
        .temp_i (temp),
        .cfg_o  (cfg),
        .wr_o   (wr),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    // Bus-level watchers: write pulses, SDA drive activity, open-drain consistency, SDA stable while SCL high.
    always @(negedge clk) begin
        if (wr) wr_cnt++;
        if (bus.sda_t_o) sda_t_seen = 1'b1;
        if (!rst) begin
            if (bus.sda_o !== ~bus.sda_t_o) proto_bad++;
            if (scl_m && scl_prev_tb && bus.sda_t_o !== sdat_prev) proto_bad++;
        end
        scl_prev_tb = scl_m;
        sdat_prev   = bus.sda_t_o;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] model_cfg();
        return {m_reg[3], m_reg[2], m_reg[1]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        m_ptr = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #T;
        scl_m = 1'b1; #T;
        sda_m = 1'b0; #T;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #T;
        scl_m = 1'b1; #T;
        sda_m = 1'b1; #T;
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; #T;
        scl_m = 1'b1; #T;
        scl_m = 1'b0; #Q;
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; #T;
        scl_m = 1'b1; #(T/2);
        b = bus.sda_i; #(T/2);
        scl_m = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack);
    endtask

    // Write transaction of wbuf[0..n-1]; first data byte is the pointer.
    task automatic do_write(input logic [7:0] addr8, input int n, input bit with_stop);
        logic ack;
        bit   match;
        bit   first;
        match = (addr8 == 8'h90);
        first = 1'b1;
        i2c_start();
        write_byte(addr8, ack);
        check_eq("addr_ack", {31'd0, ack}, match ? 32'd0 : 32'd1);
        for (int i = 0; i < n; i++) begin
            write_byte(wbuf[i], ack);
            check_eq("data_ack", {31'd0, ack}, match ? 32'd0 : 32'd1);
            if (match) begin
                if (first) begin
                    m_ptr = int'(wbuf[i][1:0]);
                    first = 1'b0;
                end else begin
                    if (m_ptr != 0) begin
                        m_reg[m_ptr] = wbuf[i];
                        m_wr++;
                    end
                    m_ptr = (m_ptr + 1) % 4;
                end
            end
        end
        if (with_stop) begin
            i2c_stop();
            check_eq("wr_busy", {31'd0, busy}, 32'd0);
        end
        check_eq("wr_cfg", {8'd0, cfg}, {8'd0, model_cfg()});
        check_eq("wr_cnt", wr_cnt, m_wr);
    endtask

    // Read transaction of n bytes from the current pointer (repeated START if bus is busy).
    task automatic do_read(input int n);
        logic       ack;
        logic [7:0] d;
        logic [7:0] exp;
        i2c_start();
        write_byte(8'h91, ack);
        check_eq("rd_addr_ack", {31'd0, ack}, 32'd0);
        for (int k = 0; k < n; k++) begin
            exp = (m_ptr == 0) ? temp : m_reg[m_ptr];
            read_byte(d, (k == n - 1));
            check_eq("rd_data", {24'd0, d}, {24'd0, exp});
            m_ptr = (m_ptr + 1) % 4;
        end
        check_eq("nack_release", {31'd0, bus.sda_t_o}, 32'd0);
        i2c_stop();
        check_eq("rd_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic ack;
        logic [23:0] cfg_hold;
        int          wr_hold;
        int          op;
        int          n;

        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_sda_t", {31'd0, bus.sda_t_o}, 32'd0);
        check_eq("rst_sda_o", {31'd0, bus.sda_o}, 32'd1);
        check_eq("rst_cfg", {8'd0, cfg}, 32'd0);
        check_eq("rst_wr", {31'd0, wr}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Plain register write of reg1/reg2, then confirm the pointer landed on 3.
        wbuf[0] = 8'h01; wbuf[1] = 8'hA5; wbuf[2] = 8'h3C;
        do_write(8'h90, 3, 1'b1);
        check_eq("t1_cfg", {8'd0, cfg}, 32'h003CA5);
        check_eq("t1_wr", wr_cnt, 2);
        do_read(1);

        // Pointer write, repeated START, read temp then reg1.
        temp = 8'h19;
        wbuf[0] = 8'h00;
        do_write(8'h90, 1, 1'b0);
        do_read(2);

        // Wrong address: never driven, registers untouched, busy drops after the address byte.
        sda_t_seen = 1'b0;
        cfg_hold = cfg;
        i2c_start();
        write_byte(8'h92, ack);
        check_eq("mis_ack", {31'd0, ack}, 32'd1);
        check_eq("mis_busy", {31'd0, busy}, 32'd0);
        write_byte(8'h01, ack);
        write_byte(8'h77, ack);
        i2c_stop();
        check_eq("mis_drive", {31'd0, sda_t_seen}, 32'd0);
        check_eq("mis_cfg", {8'd0, cfg}, {8'd0, cfg_hold});

        // STOP in the middle of a data byte.
        cfg_hold = cfg;
        wr_hold  = wr_cnt;
        i2c_start();
        write_byte(8'h90, ack);
        write_byte(8'h02, ack);
        m_ptr = 2;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        i2c_stop();
        check_eq("mid_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_sda_t", {31'd0, bus.sda_t_o}, 32'd0);
        check_eq("mid_cfg", {8'd0, cfg}, {8'd0, cfg_hold});
        check_eq("mid_wr", wr_cnt, wr_hold);
        do_read(1);

        // From reset: pointer 3, write reg3 then a dropped reg0 write, pointer wraps to 1.
        do_reset();
        wbuf[0] = 8'h03; wbuf[1] = 8'h11; wbuf[2] = 8'h22;
        wr_hold = wr_cnt;
        do_write(8'h90, 3, 1'b1);
        check_eq("t4_cfg", {8'd0, cfg}, 32'h110000);
        check_eq("t4_wr", wr_cnt - wr_hold, 1);
        temp = 8'h5A;
        wbuf[0] = 8'h01; wbuf[1] = 8'h66;
        do_write(8'h90, 2, 1'b1);
        do_read(2);

        // Randomized mix of writes, pointer-set reads and continued reads.
        for (int it = 0; it < 16; it++) begin
            op = $urandom_range(2, 0);
            temp = 8'($urandom);
            if (op == 0) begin
                n = $urandom_range(4, 1);
                for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
                do_write(($urandom_range(3, 0) == 0) ? 8'h94 : 8'h90, n, 1'b1);
            end else if (op == 1) begin
                wbuf[0] = 8'($urandom_range(3, 0));
                do_write(8'h90, 1, 1'b0);
                do_read($urandom_range(3, 1));
            end else begin
                do_read($urandom_range(3, 1));
            end
        end

        // Reset while the target holds the address ACK.
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 4);
        sda_m = 1'b1; #T;
        scl_m = 1'b1; #(T/2);
        check_eq("ack_driven", {31'd0, bus.sda_t_o}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("arst_sda_t", {31'd0, bus.sda_t_o}, 32'd0);
        check_eq("arst_sda_o", {31'd0, bus.sda_o}, 32'd1);
        check_eq("arst_cfg", {8'd0, cfg}, 32'd0);
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        #(T/2);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        do_read(1);

        check_eq("protocol", proto_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
